// File: rtl/io_pkg.sv
// Shared IO memory map and FSM state type for the bit-addressed IO memory
// and its word-level initiator.
package io_pkg;

  localparam int IO_OUT_LAST = 35;
  localparam int IO_IN_FIRST = 36;
  localparam int IO_SW_FIRST = 71;
  localparam int IO_LAST     = 75;
  localparam int IO_WORD_W   = 24;
  localparam int IO_MAX_LEN  = 24;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    VERIFY,
    RESP
  } io_state_t;

endpackage

// File: rtl/io_word_master_if.sv
// Request/response handshake plus per-bit IO memory port between the
// core-side initiator (master) and its environment (slave).
interface io_word_master_if
  import io_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = IO_WORD_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_base;
  logic [4:0]        req_len;
  logic [WORD_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] io_address;
  logic              io_en;
  logic [WORD_W-1:0] io_dataIn;
  logic [WORD_W-1:0] io_dataOut;

  modport master (
    input  req_valid, req_write, req_base,
    input  req_len, req_wdata, rsp_ready,
    input  io_dataOut,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, io_address, io_en,
    output io_dataIn
  );

  modport slave (
    output req_valid, req_write, req_base,
    output req_len, req_wdata, rsp_ready,
    output io_dataOut,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, io_address, io_en,
    input  io_dataIn
  );

endinterface

// File: rtl/io_word_master.sv
// Word-to-bit initiator: scatters writes / gathers reads one IO bit per cycle.
// Define IO_WRITE_VERIFY_EN to re-read and compare every written bit.
module io_word_master
  import io_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = IO_WORD_W,
  parameter int OUT_LAST = IO_OUT_LAST
) (
  input  logic           clk,
  input  logic           rst,
  io_word_master_if.master bus
);

  localparam int XW = ADDR_W + 1;

  io_state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        len_q, len_d;
  logic [4:0]        idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [XW-1:0] req_last;
  logic [XW-1:0] cur_addr;
  logic          accept;
  logic          illegal;
  logic          last_bit;
  logic          rd_bit;
  logic          unused_dout;

  // One bit wider than the address so base+len-1 cannot wrap
  assign req_last = XW'(bus.req_base) + XW'(bus.req_len) - XW'(1);
  assign cur_addr = XW'(base_q) + XW'(idx_q);

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign illegal  = (bus.req_len == 5'd0)
                 || (bus.req_len > 5'(IO_MAX_LEN))
                 || (bus.req_write
                     && (req_last > XW'(OUT_LAST)));
  assign last_bit = (idx_q == len_q - 5'd1);

  // Unmapped addresses read as 0; only bit 0 of the memory is meaningful
  assign rd_bit = (cur_addr > XW'(IO_LAST))
                ? 1'b0 : bus.io_dataOut[0];
  assign unused_dout = ^bus.io_dataOut[WORD_W-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal)            state_d = RESP;
          else if (bus.req_write) state_d = WRITE;
          else                    state_d = READ;
        end
      end
      WRITE: begin
        if (last_bit) begin
`ifdef IO_WRITE_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = RESP;
`endif
        end
      end
      READ: begin
        if (last_bit) state_d = RESP;
      end
`ifdef IO_WRITE_VERIFY_EN
      VERIFY: begin
        if (last_bit) state_d = RESP;
      end
`endif
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          base_d  = bus.req_base;
          len_d   = bus.req_len;
          wdata_d = bus.req_wdata;
          idx_d   = 5'd0;
          rdata_d = '0;
          err_d   = illegal;
        end
      end
      WRITE: begin
        idx_d = last_bit ? 5'd0 : idx_q + 5'd1;
      end
      READ: begin
        rdata_d[idx_q] = rd_bit;
        idx_d          = idx_q + 5'd1;
      end
`ifdef IO_WRITE_VERIFY_EN
      VERIFY: begin
        rdata_d[idx_q] = rd_bit;
        idx_d          = idx_q + 5'd1;
        if (rd_bit != wdata_q[idx_q]) err_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_rdata  = '0;
    bus.rsp_err    = 1'b0;
    bus.io_address = '0;
    bus.io_en      = 1'b0;
    bus.io_dataIn  = '0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
      end
      WRITE: begin
        bus.io_address = cur_addr[ADDR_W-1:0];
        bus.io_en      = 1'b1;
        bus.io_dataIn  = WORD_W'(wdata_q[idx_q]);
      end
      READ, VERIFY: begin
        bus.io_address = cur_addr[ADDR_W-1:0];
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_word_master.sv
// Scoreboard bench for io_word_master with a behavioural bit-addressed IO
// memory; builds with or without IO_WRITE_VERIFY_EN.
module tb_io_word_master;

`ifdef IO_WRITE_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [23:0] rd;
    bit          err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    bit         d;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   stub = 1'b0;
  bit   in_rsp = 1'b0;
  int   first_cyc = 0;

  logic [35:0] out_mem = '0;
  logic [39:0] in_reg;

  exp_t   rsp_q[$];
  pulse_t pulse_q[$];
  exp_t   e;
  pulse_t p;

  io_word_master_if #(.ADDR_W(8), .WORD_W(24)) bus ();

  io_word_master #(
    .ADDR_W(8),
    .WORD_W(24),
    .OUT_LAST(35)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // IO memory: writable GPIO-out bits, read path with junk upper bits
  always @(posedge clk)
    if (rst && bus.io_en && bus.io_address <= 8'd35)
      out_mem[bus.io_address[5:0]] <= bus.io_dataIn[0];

  always_comb begin
    bus.io_dataOut = '1;
    if (bus.io_address <= 8'd35)
      bus.io_dataOut = {23'h2AAAAA,
                        out_mem[bus.io_address[5:0]] ^ stub};
    else if (bus.io_address <= 8'd75)
      bus.io_dataOut = {23'h2AAAAA,
                        in_reg[6'(bus.io_address - 8'd36)] ^ stub};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      in_rsp = 1'b0;
    end else begin
      if (bus.io_en) begin
        if (pulse_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pulse: io_en at addr %0d, expected none",
                   bus.io_address);
        end else begin
          p = pulse_q.pop_front();
          chk("pulse_addr", 32'(bus.io_address), 32'(p.a));
          chk("pulse_data", 32'(bus.io_dataIn), 32'(p.d));
        end
      end
      if (bus.rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          first_cyc = cyc;
        end
        if (bus.rsp_ready) begin
          in_rsp = 1'b0;
          if (rsp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: got rsp_valid, expected none");
          end else begin
            e = rsp_q.pop_front();
            chk({e.nm, "/rdata"}, 32'(bus.rsp_rdata), 32'(e.rd));
            chk({e.nm, "/err"}, 32'(bus.rsp_err), 32'(e.err));
            chk({e.nm, "/latency"}, first_cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  task automatic send(input string nm, input bit wr,
                      input logic [7:0] b, input logic [4:0] l,
                      input logic [23:0] wd, input logic [23:0] rd,
                      input bit err, input int lat, input bit push);
    int n;
    @(negedge clk);
    bus.req_write = wr;
    bus.req_base  = b;
    bus.req_len   = l;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s/ready_timeout: got req_ready=0 expected 1", nm);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (push) rsp_q.push_back('{nm, rd, err, lat, cyc});
  endtask

  task automatic wr(input string nm, input logic [7:0] b,
                    input logic [4:0] l, input logic [23:0] wd,
                    input bit legal);
    logic [23:0] m;
    logic [23:0] rd;
    int          lat;
    m = '0;
    rd = '0;
    lat = 0;
    if (legal) begin
      for (int i = 0; i < int'(l); i++) begin
        m[i] = 1'b1;
        pulse_q.push_back('{b + 8'(i), wd[i]});
      end
      lat = VER ? 2 * int'(l) : int'(l);
      if (VER) rd = (wd & m) ^ (stub ? m : 24'h0);
    end
    send(nm, 1'b1, b, l, wd, rd, !legal || (VER && stub), lat, 1'b1);
  endtask

  task automatic rd(input string nm, input logic [7:0] b,
                    input logic [4:0] l, input logic [23:0] want,
                    input bit legal);
    send(nm, 1'b0, b, l, 24'h0, legal ? want : 24'h0, !legal,
         legal ? int'(l) : 0, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || pulse_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || pulse_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d rsp / %0d pulses pending, expected 0",
               rsp_q.size(), pulse_q.size());
      rsp_q.delete();
      pulse_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_base  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    // 71..74 switches = 4'b1010 (bit0 at 71), 75 = 1, 36..70 gpio-in
    in_reg = {1'b1, 4'b1010, 35'h1_2345_6789};

    repeat (3) @(negedge clk);
    chk("rst/req_ready", 32'(bus.req_ready), 1);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 0);
    chk("rst/rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst/io_en", 32'(bus.io_en), 0);
    chk("rst/io_address", 32'(bus.io_address), 0);
    chk("rst/io_dataIn", 32'(bus.io_dataIn), 0);
    rst = 1'b1;
    @(negedge clk);

    wr("wr_a5", 8'd4, 5'd8, 24'h0000A5, 1'b1);
    drain();
    chk("gpio_out_4_11", 32'(out_mem[11:4]), 32'h0A5);

    rd("rd_out", 8'd4, 5'd8, 24'h0000A5, 1'b1);
    rd("rd_gpio_in", 8'd36, 5'd24, 24'h456789, 1'b1);
    wr("wr_ovf", 8'd30, 5'd8, 24'h0000FF, 1'b0);
    rd("rd_len0", 8'd0, 5'd0, 24'h0, 1'b0);
    rd("rd_len25", 8'd0, 5'd25, 24'h0, 1'b0);
    rd("rd_sw_edge", 8'd74, 5'd4, 24'h000003, 1'b1);
    wr("wr_edge", 8'd28, 5'd8, 24'h00003C, 1'b1);
    wr("wr_last", 8'd35, 5'd1, 24'h000001, 1'b1);
    drain();
    chk("gpio_out_28_35", 32'(out_mem[35:28]), 32'h0BC);

    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rd("rd_hold", 8'd4, 5'd2, 24'h000001, 1'b1);
    repeat (10) @(negedge clk);
    chk("rsp_hold", 32'(bus.rsp_valid), 1);
    bus.rsp_ready = 1'b1;
    drain();

    // Abort a 10-bit write during its third bit
    pulse_q.push_back('{8'd20, 1'b1});
    pulse_q.push_back('{8'd21, 1'b1});
    send("wr_abort", 1'b1, 8'd20, 5'd10, 24'h0003FF, 24'h0, 1'b0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort/io_en", 32'(bus.io_en), 0);
    chk("abort/req_ready", 32'(bus.req_ready), 1);
    chk("abort/rsp_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort/bits_20_29", 32'(out_mem[29:20]), 32'h003);
    chk("abort/pulses_left", pulse_q.size(), 0);

`ifdef IO_WRITE_VERIFY_EN
    stub = 1'b1;
    wr("wr_vfy_bad", 8'd0, 5'd4, 24'h000009, 1'b1);
    drain();
    stub = 1'b0;
`endif

    wr("wr_b2b", 8'd12, 5'd3, 24'h000005, 1'b1);
    rd("rd_b2b", 8'd12, 5'd3, 24'h000005, 1'b1);
    drain();
    chk("end/rsp_q_empty", rsp_q.size(), 0);
    chk("end/pulse_q_empty", pulse_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_word_master.md
# io_word_master

Bus-side initiator for the bit-addressed IO memory. Takes word-level read/write requests from the core and turns them into the per-bit address/enable/data cycles the IO memory expects. Writes scatter up to 24 bits of a word onto consecutive output bits (GPIO out region, addresses 0–35). Reads gather up to 24 consecutive bits (output region, GPIO-in region 36–70, switch region 71–75) back into a right-aligned word.

## Interface
Parameters:
- ADDR_W, 8, IO address width
- WORD_W, 24, request/response data width
- OUT_LAST, 35, highest writable bit address

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain only
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready at clk edge
- req_write  in  1  1 = write, 0 = read
- req_base  in  ADDR_W  first bit address
- req_len  in  5  bit count, legal 1..24
- req_wdata  in  WORD_W  write bits; bit i goes to address base+i
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  WORD_W  read result; bit i from base+i; upper bits 0
- rsp_err  out  1  request rejected, or verify mismatch
- io_address  out  ADDR_W  to IO memory address
- io_en  out  1  to IO memory write enable
- io_dataIn  out  WORD_W  to IO memory dataIn; only bit 0 is meaningful
- io_dataOut  in  WORD_W  from IO memory dataOut; combinational in io_address

## Operation
- FSM states: IDLE, WRITE, READ, VERIFY, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch base, len, wdata, write; clear the bit index i and rdata.
- Legality check at accept:
  - len==0 or len>24 is illegal.
  - For writes, base+len-1 > OUT_LAST is also illegal. Compute this sum 9 bits wide so it cannot wrap.
  - Illegal request: go straight to RESP with rsp_err=1. No io_en pulse is issued.
- WRITE:
  - Each cycle drives io_address=base+i, io_en=1, io_dataIn={23'b0,wdata[i]}; then i++.
  - After i==len-1, go to VERIFY if enabled, else RESP.
- READ:
  - Each cycle drives io_address=base+i with io_en=0.
  - At the edge, capture rdata[i] = io_dataOut[0]; then i++.
  - After i==len-1, go to RESP.
  - Addresses above 75 read as 0 and are not an error.
  - An address in 71–75 returns only the bit-0 slice of io_dataOut.
- RESP:
  - rsp_valid=1, with rsp_rdata (reads) or 0 (writes), and rsp_err.
  - On rsp_ready, go to IDLE.
  - req_ready=0 in every state except IDLE.
- Outside WRITE, io_en is 0. io_address and io_dataIn are 0 in IDLE and RESP.

## Timing
- Reset (rst low, asynchronous) forces IDLE, with all outputs 0 except req_ready=1.
  - Asserting rst mid-transfer drops io_en immediately.
  - Bits already written stay written.
  - No response is produced for the aborted request.
- Write latency: accept edge, then len WRITE cycles, then VERIFY (len cycles when enabled), then RESP. rsp_valid rises len (or 2·len) cycles after accept.
- Read latency: rsp_valid rises len cycles after accept.
- Back-to-back: a new request is accepted the cycle after the RESP handshake. No overlap.
- io_en is a registered output: exactly len single-cycle pulses per legal write, at consecutive addresses.

## Configuration
- Macro IO_WRITE_VERIFY_EN.
- Defined:
  - After WRITE, VERIFY re-reads each of the len bits (io_en=0) and compares io_dataOut[0] against wdata[i].
  - Any mismatch sets rsp_err=1; rsp_rdata carries the re-read bits.
- Undefined:
  - The VERIFY state is absent, and WRITE goes directly to RESP.
  - rsp_err is set only on illegal requests.

## Structure
- Shared package io_pkg holds:
  - the state enum io_state_t;
  - the constants IO_OUT_LAST=35, IO_IN_FIRST=36, IO_SW_FIRST=71, IO_LAST=75, IO_WORD_W=24, IO_MAX_LEN=24.
- The IO memory region boundaries are used by both this block and the IO memory, so they live in io_pkg.
- No sub-module: the FSM, index counter and shift/assembly logic sit in one module.

## Test plan
- Write base=4, len=8, wdata=0xA5 → io_en pulses at addresses 4..11 carrying 1,0,1,0,0,1,0,1. The GPIO-out bits match. rsp_err=0.
- Set switches=4'b1010 and drive the GPIO-in region with a known pattern. Read base=36, len=24 → rsp_rdata equals gpio-in bits 0..23.
- Illegal requests get rsp_err=1, zero io_en pulses, and RESP reached one cycle after accept:
  - write base=30, len=8;
  - read len=0;
  - read len=25.
- Read base=74, len=4 → bits from 74, 75 plus 0s from 76, 77. rsp_err=0.
- Pull rst low on the 3rd cycle of a len=10 write → io_en drops immediately, only bits 0–1 are written, req_ready=1, and no rsp_valid.
- With IO_WRITE_VERIFY_EN defined, force a mismatch by stubbing the IO memory read path → rsp_err=1. The normal write returns rsp_err=0 after 2·len cycles.
